// File: rtl/cpu_pkg.sv
// Shared opcode and FSM-state definitions for the CPU control path.
// Opcode values double as the ALU operation select codes.
package cpu_pkg;

  localparam int unsigned XLEN     = 16;
  localparam int unsigned OpW      = 4;
  localparam int unsigned RegAddrW = 4;

  typedef enum logic [OpW-1:0] {
    OpNop  = 4'b0000,
    OpAdd  = 4'b1000,
    OpSub  = 4'b0100,
    OpBeq  = 4'b1100,
    OpBlt  = 4'b1101,
    OpBgt  = 4'b1110,
    OpHalt = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StWriteback,
    StHalt
  } state_e;

  function automatic logic is_alu_op(input logic [OpW-1:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

  function automatic logic is_branch(input logic [OpW-1:0] op);
    return (op == OpBeq) || (op == OpBlt) || (op == OpBgt);
  endfunction

  function automatic logic is_legal(input logic [OpW-1:0] op);
    return is_alu_op(op) || is_branch(op) || (op == OpNop) || (op == OpHalt);
  endfunction

  function automatic logic [XLEN-1:0] sext_offset(input logic [3:0] off);
    return {{(XLEN - 4){off[3]}}, off};
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXECUTE/WRITEBACK sequencing,
// instruction register, registered ALU results and program counter.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic [OpW-1:0]      alu_code,
  output logic [RegAddrW-1:0] rs1_addr,
  output logic [RegAddrW-1:0] rs2_addr,
  input  logic [XLEN-1:0]     accum,
  input  logic                branch_check,
  output logic                reg_we,
  output logic [RegAddrW-1:0] rd_addr,
  output logic [XLEN-1:0]     wr_data,
  output logic [XLEN-1:0]     pc,
  output logic                halted,
  output logic                illegal
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] accum_q;
  logic            branch_q;
  logic [OpW-1:0]  op;

  assign op        = ir_q[15:12];
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; run only matters while idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      state_d = run ? StFetch : StIdle;
      StFetch:     state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = (op == OpHalt) ? StHalt : StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    alu_code = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    reg_we   = 1'b0;
    rd_addr  = '0;
    wr_data  = '0;
    illegal  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      StFetch: imem_req = 1'b1;
      StExecute: begin
        if (is_alu_op(op) || is_branch(op)) begin
          alu_code = op;
        end
        rs1_addr = ir_q[7:4];
        rs2_addr = ir_q[3:0];
      end
      StWriteback: begin
        if (is_alu_op(op)) begin
          reg_we  = 1'b1;
          rd_addr = ir_q[11:8];
          wr_data = accum_q;
        end
        illegal = !is_legal(op);
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  // Branch offset field is only meaningful when the registered compare says taken
  always_comb begin
    pc_next = pc_q + 16'd1;
    if (op == OpHalt) begin
      pc_next = pc_q;
    end else if (is_branch(op) && branch_q) begin
      pc_next = pc_q + sext_offset(ir_q[11:8]);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      accum_q  <= '0;
      branch_q <= 1'b0;
    end else begin
      if (state_q == StDecode) begin
        ir_q <= imem_rdata;
      end
      if (state_q == StExecute) begin
        accum_q  <= accum;
        branch_q <= branch_check;
      end
      if (state_q == StWriteback) begin
        pc_q <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: bench-side ALU, register file and instruction memory,
// plus an instruction-level reference model compared every cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic [3:0]  alu_code;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [15:0] accum;
  logic        branch_check;
  logic        reg_we;
  logic [3:0]  rd_addr;
  logic [15:0] wr_data;
  logic [15:0] pc;
  logic        halted;
  logic        illegal;

  always #5 clk = ~clk;

  control_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .alu_code     (alu_code),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .accum        (accum),
    .branch_check (branch_check),
    .reg_we       (reg_we),
    .rd_addr      (rd_addr),
    .wr_data      (wr_data),
    .pc           (pc),
    .halted       (halted),
    .illegal      (illegal)
  );

  logic [15:0] mem       [256];
  logic [15:0] init_regs [16];
  logic [15:0] regs      [16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment: register file (reloaded on reset) and one-cycle-latency memory
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_regs[i];
    end else if (reg_we) begin
      regs[rd_addr] <= wr_data;
    end
    imem_rdata <= imem_req ? mem[imem_addr[7:0]] : 16'($urandom);
  end

  // Environment: ALU
  logic [15:0] alu_a, alu_b;
  always_comb begin
    alu_a        = regs[rs1_addr];
    alu_b        = regs[rs2_addr];
    accum        = alu_a ^ alu_b;
    branch_check = alu_a[0];
    case (alu_code)
      4'h8: accum = alu_a + alu_b;
      4'h4: accum = alu_a - alu_b;
      4'hC: branch_check = (alu_a == alu_b);
      4'hD: branch_check = ($signed(alu_a) < $signed(alu_b));
      4'hE: branch_check = ($signed(alu_a) > $signed(alu_b));
      default: ;
    endcase
  end

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'h0, 4'h8, 4'h4, 4'hC, 4'hD, 4'hE, 4'hF};
  endfunction

  // Reference model: mode 0 idle, 1 running (phase = cycle within instruction), 2 halted
  int          m_mode = 0;
  int          m_phase = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_ir = 16'h0;
  logic [15:0] m_regs [16];

  always @(negedge clk) begin
    logic [3:0]  op;
    logic [15:0] a, b, e_wd;
    logic [3:0]  e_alu, e_rs1, e_rs2, e_rd;
    logic        e_req, e_we, e_ill, taken;
    op = m_ir[15:12];
    a  = m_regs[m_ir[7:4]];
    b  = m_regs[m_ir[3:0]];
    if (m_valid) begin
      e_req = 0; e_alu = 0; e_rs1 = 0; e_rs2 = 0; e_we = 0; e_rd = 0; e_wd = 0; e_ill = 0;
      if (m_mode == 1) begin
        if (m_phase == 0) e_req = 1;
        if (m_phase == 2) begin
          e_alu = (op inside {4'h8, 4'h4, 4'hC, 4'hD, 4'hE}) ? op : 4'h0;
          e_rs1 = m_ir[7:4];
          e_rs2 = m_ir[3:0];
        end
        if (m_phase == 3) begin
          if (op == 4'h8 || op == 4'h4) begin
            e_we = 1;
            e_rd = m_ir[11:8];
            e_wd = (op == 4'h8) ? a + b : a - b;
          end
          e_ill = !legal_op(op);
        end
      end
      chk("imem_req", imem_req, e_req);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("alu_code", alu_code, e_alu);
      chk("rs1_addr", rs1_addr, e_rs1);
      chk("rs2_addr", rs2_addr, e_rs2);
      chk("reg_we", reg_we, e_we);
      chk("rd_addr", rd_addr, e_rd);
      chk("wr_data", wr_data, e_wd);
      chk("illegal", illegal, e_ill);
      chk("halted", halted, m_mode == 2);
    end
    // advance with the inputs the next rising edge will sample
    if (!rst_n) begin
      m_valid = 1;
      m_mode  = 0;
      m_phase = 0;
      m_pc    = 16'h0000;
      m_regs  = init_regs;
    end else if (m_valid) begin
      if (m_mode == 0 && run) begin
        m_mode  = 1;
        m_phase = 0;
        m_ir    = mem[m_pc[7:0]];
      end else if (m_mode == 1) begin
        if (m_phase < 3) begin
          m_phase++;
        end else begin
          if (op == 4'h8) m_regs[m_ir[11:8]] = a + b;
          if (op == 4'h4) m_regs[m_ir[11:8]] = a - b;
          if (op == 4'hF) begin
            m_mode = 2;
          end else begin
            taken = (op == 4'hC && a == b) ||
                    (op == 4'hD && $signed(a) < $signed(b)) ||
                    (op == 4'hE && $signed(a) > $signed(b));
            m_pc    = taken ? m_pc + {{12{m_ir[11]}}, m_ir[11:8]} : m_pc + 16'd1;
            m_phase = 0;
            m_ir    = mem[m_pc[7:0]];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    run   = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) init_regs[i] = 16'(i * 3 + 1);
  endtask

  // Pulse run, then wait n full instructions; lands in FETCH of instruction n
  task automatic start(input int n);
    run = 1;
    tick();
    run = 0;
    repeat (4 * n) tick();
  endtask

  function automatic logic [15:0] rand_instr();
    int unsigned sel;
    logic [3:0]  op;
    sel = $urandom_range(0, 19);
    if      (sel < 4)  op = 4'h8;
    else if (sel < 7)  op = 4'h4;
    else if (sel < 9)  op = 4'hC;
    else if (sel < 11) op = 4'hD;
    else if (sel < 13) op = 4'hE;
    else if (sel < 15) op = 4'h0;
    else if (sel < 16) op = 4'hF;
    else begin
      op = 4'($urandom_range(0, 15));
      while (legal_op(op)) op = 4'($urandom_range(0, 15));
    end
    return {op, 12'($urandom)};
  endfunction

  initial begin
    clear_env();
    init_regs[1] = 16'd5;
    init_regs[2] = 16'd7;
    mem[0] = 16'h8312;
    mem[1] = 16'hF000;
    do_reset();
    chk("reset_pc", pc, 16'h0000);
    chk("reset_imem_addr", imem_addr, 16'h0000);
    chk("reset_req", imem_req, 0);
    chk("reset_halted", halted, 0);

    // ADD r3 = r1 + r2
    start(0);
    chk("add_fetch_req", imem_req, 1);
    tick(); tick(); tick();
    chk("add_we", reg_we, 1);
    chk("add_rd", rd_addr, 4'd3);
    chk("add_wdata", wr_data, 16'd12);
    tick();
    chk("add_pc", pc, 16'd1);
    repeat (4) tick();
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 16'd1);
    run = 1;
    repeat (8) begin
      tick();
      chk("halt_no_req", imem_req, 0);
    end
    do_reset();
    chk("halt_reset_pc", pc, 16'h0000);
    chk("halt_reset_flag", halted, 0);

    // BEQ taken / not taken / negative offset
    clear_env();
    init_regs[1] = 16'd3;
    init_regs[2] = 16'd3;
    mem[4] = 16'hC212;
    mem[6] = 16'hF000;
    do_reset();
    start(5);
    chk("beq_taken_pc", pc, 16'd6);
    init_regs[2] = 16'd4;
    do_reset();
    start(5);
    chk("beq_not_taken_pc", pc, 16'd5);
    init_regs[2] = 16'd3;
    mem[4] = 16'hCE12;
    do_reset();
    start(5);
    chk("beq_back_pc", pc, 16'd2);

    // Wrap: branch to FFFF, then BGT +1 wraps to 0000
    clear_env();
    mem[0]       = 16'hCF11;
    mem[255]     = 16'hE123;
    init_regs[2] = 16'd9;
    init_regs[3] = 16'd1;
    do_reset();
    start(1);
    chk("wrap_ffff_pc", pc, 16'hFFFF);
    repeat (4) tick();
    chk("wrap_zero_pc", pc, 16'h0000);

    // Illegal opcode
    clear_env();
    mem[0] = 16'h3123;
    do_reset();
    start(0);
    tick(); tick(); tick();
    chk("illegal_pulse", illegal, 1);
    chk("illegal_no_we", reg_we, 0);
    tick();
    chk("illegal_pc", pc, 16'd1);
    chk("illegal_clear", illegal, 0);

    // Reset during EXECUTE of ADD
    clear_env();
    init_regs[1] = 16'd5;
    init_regs[2] = 16'd7;
    mem[0] = 16'h8312;
    do_reset();
    start(0);
    tick(); tick();
    chk("exec_alu_code", alu_code, 4'h8);
    rst_n = 0;
    tick();
    chk("abort_no_we", reg_we, 0);
    chk("abort_pc", pc, 16'h0000);
    rst_n = 1;
    tick();
    chk("abort_idle_no_we", reg_we, 0);
    chk("abort_idle_no_req", imem_req, 0);

    // Randomized programs with random run and occasional reset
    repeat (20) begin
      rst_n = 0;
      run   = 0;
      for (int i = 0; i < 256; i++) mem[i] = rand_instr();
      for (int i = 0; i < 16; i++)
        init_regs[i] = (i < 8) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      tick();
      tick();
      rst_n = 1;
      repeat (150) begin
        run   = ($urandom_range(0, 3) == 0);
        rst_n = ($urandom_range(0, 99) != 0);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the program counter value loaded at reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 run  input  1  SHALL start execution when high in IDLE.
REQ-005 imem_req  output  1  SHALL pulse high for one cycle to request an instruction.
REQ-006 imem_addr  output  16  SHALL carry the fetch address, equal to pc.
REQ-007 imem_rdata  input  16  SHALL be the instruction, valid exactly one cycle after imem_req.
REQ-008 alu_code  output  4  SHALL carry the ALU operation select to the ALU.
REQ-009 rs1_addr, rs2_addr  output  4 each  SHALL carry the register-file read addresses; register reads are combinational and feed the ALU reg_data1/reg_data2.
REQ-010 accum  input  16  SHALL be the ALU result.
REQ-011 branch_check  input  1  SHALL be the ALU compare result.
REQ-012 reg_we  output  1  SHALL be the register-file write enable.
REQ-013 rd_addr  output  4 and wr_data  output  16  SHALL carry the write address and data.
REQ-014 pc  output  16  SHALL show the current program counter.
REQ-015 halted  output  1 and illegal  output  1  SHALL flag HALT state and a one-cycle illegal-opcode pulse.

Function
REQ-016 Instruction format: [15:12] opcode, [11:8] rd (ALU ops) or signed branch offset (branches), [7:4] rs1, [3:0] rs2.
REQ-017 Opcodes: 0000 NOP, 1000 ADD, 0100 SUB, 1100 BEQ, 1101 BLT, 1110 BGT, 1111 HALT; all others illegal.
REQ-018 FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-019 Transitions: IDLE->FETCH when run=1; FETCH->DECODE; DECODE->EXECUTE; EXECUTE->WRITEBACK; WRITEBACK->FETCH, or ->HALT if opcode is HALT; HALT is terminal until reset.
REQ-020 FETCH: imem_req=1, imem_addr=pc for exactly one cycle.
REQ-021 DECODE: ir SHALL capture imem_rdata.
REQ-022 EXECUTE: alu_code SHALL equal ir[15:12] for ADD/SUB/BEQ/BLT/BGT and 4'b0000 otherwise; rs1_addr=ir[7:4], rs2_addr=ir[3:0]; accum and branch_check SHALL be registered at the end of the cycle.
REQ-023 WRITEBACK: for ADD/SUB, reg_we=1 for one cycle, rd_addr=ir[11:8], wr_data=registered accum; otherwise reg_we=0.
REQ-024 WRITEBACK PC update: pc+sext(ir[11:8]) for a branch with registered branch_check=1, else pc+1, except HALT, which leaves pc unchanged; all arithmetic is modulo 2^16.
REQ-025 Illegal opcode SHALL execute as NOP and pulse illegal=1 during WRITEBACK.
REQ-026 Each instruction SHALL take exactly 4 cycles, FETCH to WRITEBACK inclusive.
REQ-027 alu_code, reg_we and imem_req SHALL be 0 in every state where not explicitly driven.
REQ-028 run is ignored outside IDLE; deasserting run mid-instruction has no effect.

Reset
REQ-029 With rst_n=0 at a clock edge: state=IDLE, pc=RESET_PC, ir=0, registered accum/branch_check=0, all outputs 0 except imem_addr=RESET_PC.
REQ-030 Reset asserted in any state, including mid-instruction or HALT, SHALL abort the instruction with no register write.

Structure
REQ-031 Opcode constants and the FSM state enumeration SHALL live in shared package cpu_pkg; opcode values SHALL equal the ALU's alu_code values.
REQ-032 No sub-module; the ALU and register file are sibling instances wired at CPU top level.

Verification
REQ-033 Reset then run=1, program 16'h8312 (ADD r3=r1+r2, r1=5, r2=7) -> reg_we pulse on cycle 4 with rd_addr=3, wr_data=12; pc=1.
REQ-034 BEQ 16'hC212 at pc=4, r1=r2 -> pc=6; same with r1!=r2 -> pc=5; offset 4'hE taken from pc=4 -> pc=2.
REQ-035 BGT with offset 1 at pc=16'hFFFF, taken -> pc wraps to 16'h0000.
REQ-036 Opcode 0011 -> illegal pulse in WRITEBACK, reg_we=0, pc+1.
REQ-037 HALT 16'hF000 -> halted=1, pc unchanged, no further imem_req; rst_n=0 -> IDLE, pc=RESET_PC.
REQ-038 rst_n=0 during EXECUTE of ADD -> no reg_we pulse, IDLE next cycle.
